// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// run/halt/step states and stage indices.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } step_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bundle between the core datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              tick_i, run_i, step_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i;
  logic              id_use1_i, id_use2_i;
  logic [REG_AW-1:0] ex_rs1_i, ex_rs2_i;
  logic [REG_AW-1:0] ex_rd_i, mem_rd_i, wb_rd_i;
  logic              ex_wen_i, mem_wen_i, wb_wen_i;
  logic              ex_load_i, redirect_i;
  logic              adv_o, pc_en_o, ifid_en_o;
  logic              ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic [1:0]        fwd_a_o, fwd_b_o;
  logic [4:0]        stage_valid_o;
  logic              halted_o;
  logic [CNT_W-1:0]  cyc_cnt_o, ret_cnt_o, stall_cnt_o, flush_cnt_o;

  modport master (
    output tick_i, run_i, step_i, id_rs1_i, id_rs2_i, id_use1_i, id_use2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i,
           ex_wen_i, mem_wen_i, wb_wen_i, ex_load_i, redirect_i,
    input  adv_o, pc_en_o, ifid_en_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
           fwd_a_o, fwd_b_o, stage_valid_o, halted_o,
           cyc_cnt_o, ret_cnt_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  tick_i, run_i, step_i, id_rs1_i, id_rs2_i, id_use1_i, id_use2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i,
           ex_wen_i, mem_wen_i, wb_wen_i, ex_load_i, redirect_i,
    output adv_o, pc_en_o, ifid_en_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
           fwd_a_o, fwd_b_o, stage_valid_o, halted_o,
           cyc_cnt_o, ret_cnt_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_step_fsm.sv
// Run/halt/single-step controller: gates the divider tick into the
// pipeline advance strobe.
//
// state | meaning
// HALT  | pipeline frozen, waiting for run_i or step_i
// RUN   | every tick advances the pipeline
// STEP  | next tick advances once, then back to HALT
module pipe_step_fsm
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic tick_i,
  input  logic run_i,
  input  logic step_i,
  output logic adv_o,
  output logic halted_o
);

  step_state_e state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= HALT;
      halted_o <= 1'b1;
    end else begin
      case (state)
        HALT: begin
          if (run_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end else if (step_i) begin
            state    <= STEP;
            halted_o <= 1'b0;
          end
        end
        RUN: begin
          if (!run_i) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
        end
        STEP: begin
          if (run_i) begin
            state <= RUN;
          end else if (tick_i) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
        end
        default: begin
          state    <= HALT;
          halted_o <= 1'b1;
        end
      endcase
    end
  end

  assign adv_o = tick_i & ((state == RUN) | (state == STEP));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline control: load-use stall, EX forwarding, redirect flush,
// stage valid tracking. Performance counters exist only with PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int CNT_W         = 32,
  parameter int RESOLVE_STAGE = 3
) (
  input logic              clk,
  input logic              rstn,
  pipe_hazard_ctrl_if.slave bus
);

  if (RESOLVE_STAGE != 2 && RESOLVE_STAGE != 3) begin : gBadResolve
    $error("pipe_hazard_ctrl: RESOLVE_STAGE must be 2 (EX) or 3 (MEM)");
  end

  localparam logic FLUSH_EXMEM = (RESOLVE_STAGE == 3);

  function automatic fwd_sel_e fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] memRd, input logic memWen,
    input logic [REG_AW-1:0] wbRd,  input logic wbWen
  );
    if (memWen && memRd != '0 && memRd == rs) return FWD_MEM;
    if (wbWen && wbRd != '0 && wbRd == rs)    return FWD_WB;
    return FWD_RF;
  endfunction

  logic adv, hz, stall, redir;
  logic ifidFlush, idexFlush, exmemFlush;
  logic [4:0] validQ;

  pipe_step_fsm uFsm (
    .clk      (clk),
    .rstn     (rstn),
    .tick_i   (bus.tick_i),
    .run_i    (bus.run_i),
    .step_i   (bus.step_i),
    .adv_o    (adv),
    .halted_o (bus.halted_o)
  );

  assign redir = bus.redirect_i;
  assign hz = bus.ex_load_i & bus.ex_wen_i & (bus.ex_rd_i != '0) &
              ((bus.id_use1_i & (bus.id_rs1_i == bus.ex_rd_i)) |
               (bus.id_use2_i & (bus.id_rs2_i == bus.ex_rd_i)));
  // A redirect kills the dependent ID instruction anyway, so it never stalls.
  assign stall      = hz & ~redir;
  assign ifidFlush  = adv & redir;
  assign idexFlush  = adv & (redir | hz);
  assign exmemFlush = adv & redir & FLUSH_EXMEM;

  assign bus.adv_o         = adv;
  assign bus.pc_en_o       = adv & ~stall;
  assign bus.ifid_en_o     = adv & ~stall;
  assign bus.ifid_flush_o  = ifidFlush;
  assign bus.idex_flush_o  = idexFlush;
  assign bus.exmem_flush_o = exmemFlush;
  assign bus.fwd_a_o = fwdSel(bus.ex_rs1_i, bus.mem_rd_i, bus.mem_wen_i, bus.wb_rd_i, bus.wb_wen_i);
  assign bus.fwd_b_o = fwdSel(bus.ex_rs2_i, bus.mem_rd_i, bus.mem_wen_i, bus.wb_rd_i, bus.wb_wen_i);
  assign bus.stage_valid_o = validQ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      validQ <= 5'b00001;
    end else if (adv) begin
      validQ[STG_IF]  <= stall ? validQ[STG_IF] : 1'b1;
      validQ[STG_ID]  <= stall ? validQ[STG_ID] : (ifidFlush ? 1'b0 : validQ[STG_IF]);
      validQ[STG_EX]  <= idexFlush  ? 1'b0 : validQ[STG_ID];
      validQ[STG_MEM] <= exmemFlush ? 1'b0 : validQ[STG_EX];
      validQ[STG_WB]  <= validQ[STG_MEM];
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cycQ, retQ, stallQ, flushQ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycQ   <= '0;
      retQ   <= '0;
      stallQ <= '0;
      flushQ <= '0;
    end else if (adv) begin
      cycQ <= cycQ + CNT_W'(1);
      if (validQ[STG_WB]) retQ   <= retQ + CNT_W'(1);
      if (stall)          stallQ <= stallQ + CNT_W'(1);
      if (redir)          flushQ <= flushQ + CNT_W'(1);
    end
  end

  assign bus.cyc_cnt_o   = cycQ;
  assign bus.ret_cnt_o   = retQ;
  assign bus.stall_cnt_o = stallQ;
  assign bus.flush_cnt_o = flushQ;
`else
  assign bus.cyc_cnt_o   = '0;
  assign bus.ret_cnt_o   = '0;
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, compared against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int RS = 3;

  typedef struct {
    logic tick, run, step;
    logic [4:0] idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
    logic use1, use2, exWen, memWen, wbWen, load, redir;
  } stim_t;

  typedef struct {
    logic adv, pcEn, ifidEn, ifidFl, idexFl, exmemFl, halted;
    logic [1:0] fa, fb;
    logic [4:0] sv;
    logic [31:0] cyc, ret, stl, fls;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();
  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .RESOLVE_STAGE(RS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int nVec = 0;
  int nMis = 0;
  exp_t expQ[$];
  stim_t cur, nxt, idle;

  // reference model state
  bit mRunning, mStepPend;
  bit [4:0] mValid;
  int unsigned mCyc, mRet, mStall, mFlush;

  function automatic bit refHz(stim_t s);
    return s.load && s.exWen && s.exRd != 0 &&
           ((s.use1 && s.idRs1 == s.exRd) || (s.use2 && s.idRs2 == s.exRd));
  endfunction

  function automatic logic [1:0] refFwd(logic [4:0] rs, stim_t s);
    if (rs == 0) return 2'd0;
    if (s.memWen && s.memRd == rs) return 2'd1;
    if (s.wbWen && s.wbRd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t refExp(stim_t s);
    exp_t e;
    bit active, hz, stl;
    active = mRunning || mStepPend;
    hz = refHz(s);
    stl = hz && !s.redir;
    e.adv = s.tick && active;
    e.pcEn = e.adv && !stl;
    e.ifidEn = e.adv && !stl;
    e.ifidFl = e.adv && s.redir;
    e.idexFl = e.adv && (s.redir || hz);
    e.exmemFl = e.adv && s.redir && (RS == 3);
    e.fa = refFwd(s.exRs1, s);
    e.fb = refFwd(s.exRs2, s);
    e.sv = mValid;
    e.halted = !active;
`ifdef PIPE_PERF_CNT_EN
    e.cyc = mCyc; e.ret = mRet; e.stl = mStall; e.fls = mFlush;
`else
    e.cyc = 0; e.ret = 0; e.stl = 0; e.fls = 0;
`endif
    return e;
  endfunction

  task automatic resetModel();
    mRunning = 0; mStepPend = 0; mValid = 5'b00001;
    mCyc = 0; mRet = 0; mStall = 0; mFlush = 0;
  endtask

  // Clock-edge update: shift the valid bits toward WB, then kill what was
  // flushed or bubbled; then follow the run/halt/step rules.
  task automatic modelUpdate();
    bit active, hz, stl;
    bit [4:0] nv;
    active = mRunning || mStepPend;
    hz = refHz(cur);
    stl = hz && !cur.redir;
    if (cur.tick && active) begin
      mCyc++;
      if (mValid[4]) mRet++;
      if (stl) mStall++;
      if (cur.redir) mFlush++;
      nv = {mValid[3:0], 1'b1};
      if (stl) begin
        nv[0] = mValid[0];
        nv[1] = mValid[1];
        nv[2] = 1'b0;
      end
      if (cur.redir) begin
        nv[1] = 1'b0;
        nv[2] = 1'b0;
        if (RS == 3) nv[3] = 1'b0;
      end
      mValid = nv;
    end
    if (mRunning) begin
      if (!cur.run) mRunning = 0;
    end else if (mStepPend) begin
      if (cur.run) begin mRunning = 1; mStepPend = 0; end
      else if (cur.tick) mStepPend = 0;
    end else begin
      if (cur.run) mRunning = 1;
      else if (cur.step) mStepPend = 1;
    end
  endtask

  task automatic apply();
    bus.tick_i = cur.tick; bus.run_i = cur.run; bus.step_i = cur.step;
    bus.id_rs1_i = cur.idRs1; bus.id_rs2_i = cur.idRs2;
    bus.id_use1_i = cur.use1; bus.id_use2_i = cur.use2;
    bus.ex_rs1_i = cur.exRs1; bus.ex_rs2_i = cur.exRs2;
    bus.ex_rd_i = cur.exRd; bus.mem_rd_i = cur.memRd; bus.wb_rd_i = cur.wbRd;
    bus.ex_wen_i = cur.exWen; bus.mem_wen_i = cur.memWen; bus.wb_wen_i = cur.wbWen;
    bus.ex_load_i = cur.load; bus.redirect_i = cur.redir;
  endtask

  function automatic bit chk(string nm, logic [31:0] act, logic [31:0] req);
    if (act !== req) begin
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic checkNow(exp_t e);
    bit bad;
    nVec++;
    bad = 0;
    bad |= chk("adv_o", 32'(bus.adv_o), 32'(e.adv));
    bad |= chk("pc_en_o", 32'(bus.pc_en_o), 32'(e.pcEn));
    bad |= chk("ifid_en_o", 32'(bus.ifid_en_o), 32'(e.ifidEn));
    bad |= chk("ifid_flush_o", 32'(bus.ifid_flush_o), 32'(e.ifidFl));
    bad |= chk("idex_flush_o", 32'(bus.idex_flush_o), 32'(e.idexFl));
    bad |= chk("exmem_flush_o", 32'(bus.exmem_flush_o), 32'(e.exmemFl));
    bad |= chk("fwd_a_o", 32'(bus.fwd_a_o), 32'(e.fa));
    bad |= chk("fwd_b_o", 32'(bus.fwd_b_o), 32'(e.fb));
    bad |= chk("stage_valid_o", 32'(bus.stage_valid_o), 32'(e.sv));
    bad |= chk("halted_o", 32'(bus.halted_o), 32'(e.halted));
    bad |= chk("cyc_cnt_o", bus.cyc_cnt_o, e.cyc);
    bad |= chk("ret_cnt_o", bus.ret_cnt_o, e.ret);
    bad |= chk("stall_cnt_o", bus.stall_cnt_o, e.stl);
    bad |= chk("flush_cnt_o", bus.flush_cnt_o, e.fls);
    if (bad) nMis++;
  endtask

  // One pipeline cycle: model follows the edge, then the staged stimulus is
  // driven and its expected response queued for the monitor.
  task automatic cycle();
    @(posedge clk);
    modelUpdate();
    #1;
    cur = nxt;
    apply();
    expQ.push_back(refExp(cur));
  endtask

  task automatic midReset();
    @(negedge clk);
    #2;
    cur = idle;
    apply();
    rstn = 1'b0;
    #1;
    resetModel();
    checkNow(refExp(cur));
    #1 rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkNow(e);
    end
  end

  initial begin
    idle = '{default: '0};
    nxt = idle;
    cur = idle;
    apply();
    rstn = 1'b0;
    resetModel();
    #11 checkNow(refExp(cur));
    #1 rstn = 1'b1;

    // three single steps while halted
    repeat (3) begin
      nxt = idle; nxt.step = 1; cycle();
      nxt = idle; nxt.tick = 1; cycle();
      nxt = idle; cycle();
    end

    // load-use stall, then normal advance
    nxt = idle; nxt.run = 1; cycle();
    nxt.tick = 1; nxt.load = 1; nxt.exWen = 1; nxt.exRd = 5; nxt.idRs1 = 5; nxt.use1 = 1;
    cycle();
    nxt.load = 0; cycle();
    nxt.load = 1; nxt.exRd = 0; cycle();
    nxt.exRd = 5; nxt.use1 = 0; cycle();
    nxt.idRs2 = 5; nxt.use2 = 1; cycle();
    nxt.use2 = 0; nxt.load = 0;

    // forwarding priority and x0
    nxt.exRs1 = 7; nxt.memRd = 7; nxt.memWen = 1; nxt.wbRd = 7; nxt.wbWen = 1; cycle();
    nxt.memWen = 0; cycle();
    nxt.exRs1 = 0; cycle();
    nxt.exRs2 = 7; nxt.memWen = 1; nxt.memRd = 0; cycle();

    // redirect overriding a load-use hazard on a full pipe
    nxt = idle; nxt.run = 1; nxt.tick = 1;
    repeat (5) cycle();
    nxt.redir = 1; nxt.load = 1; nxt.exWen = 1; nxt.exRd = 5; nxt.idRs1 = 5; nxt.use1 = 1;
    cycle();
    nxt = idle; nxt.run = 1; nxt.tick = 1; cycle();

    // fresh run of ten ticks, then asynchronous reset mid-run
    midReset();
    nxt = idle; nxt.run = 1; cycle();
    nxt.tick = 1;
    repeat (10) cycle();
    nxt.tick = 0; cycle();
    nxt.tick = 1; repeat (3) cycle();
    midReset();

    // random traffic
    nxt = idle;
    for (int i = 0; i < 3000; i++) begin
      nxt.tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) nxt.run = ~nxt.run;
      nxt.step = ($urandom_range(0, 7) == 0);
      nxt.idRs1 = 5'($urandom_range(0, 3)); nxt.idRs2 = 5'($urandom_range(0, 3));
      nxt.exRs1 = 5'($urandom_range(0, 3)); nxt.exRs2 = 5'($urandom_range(0, 3));
      nxt.exRd = 5'($urandom_range(0, 3)); nxt.memRd = 5'($urandom_range(0, 3));
      nxt.wbRd = 5'($urandom_range(0, 3));
      nxt.use1 = 1'($urandom_range(0, 1)); nxt.use2 = 1'($urandom_range(0, 1));
      nxt.exWen = 1'($urandom_range(0, 1)); nxt.memWen = 1'($urandom_range(0, 1));
      nxt.wbWen = 1'($urandom_range(0, 1)); nxt.load = 1'($urandom_range(0, 1));
      nxt.redir = ($urandom_range(0, 7) == 0);
      cycle();
      if ($urandom_range(0, 499) == 0) midReset();
    end

    nxt = idle;
    cycle();
    repeat (2) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
      nMis++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
